axi_lite_master_arbiter: RTL

- Shares one AXI4-lite master port between two AXI4-lite requesters: requester 0 is the SPI-to-AXI bridge, requester 1 is the PicoRV32 core memory port.
- Grants whole transactions (write = AW+W+B, read = AR+R) to one requester at a time and routes that requester's channels straight through to the memory/peripheral interconnect.
- Sits between the masters and the AXI4-lite slave fabric.

---
 rtl/axi_arb_pkg.sv | 27 ++
 rtl/axi_lite_master_arbiter_if.sv | 51 +++++
 rtl/axi_arb_picker.sv | 49 ++++
 rtl/axi_lite_master_arbiter.sv | 134 +++++++++++++
 4 files changed

// File: rtl/axi_arb_pkg.sv
//==============================================================================
// Module      : axi_arb_pkg
// Description : Shared constants and state type for the AXI4-lite two-requester
//               arbiter (axi_lite_master_arbiter).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package axi_arb_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WR   = 2'd1;
    localparam logic [1:0] ST_RD   = 2'd2;

    localparam int NREQ    = 2;
    localparam int REQ_SPI = 0;
    localparam int REQ_CPU = 1;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_WR   = ST_WR,
        S_RD   = ST_RD
    } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/axi_lite_master_arbiter_if.sv
//==============================================================================
// Module      : axi_lite_master_arbiter_if
// Description : Requester-side (s_*) and fabric-side (axi_*) AXI4-lite signals
//               of the arbiter. 'master' is the arbiter's view, 'slave' is the
//               view of the surrounding requesters and fabric.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface axi_lite_master_arbiter_if #(
    parameter int sword = 32
);
    import axi_arb_pkg::*;

    // Requester side, bit/slice i belongs to requester i
    logic [NREQ-1:0]           s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready;
    logic [NREQ-1:0]           s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
    logic [NREQ*sword-1:0]     s_awaddr, s_araddr, s_wdata;
    logic [NREQ*3-1:0]         s_awprot, s_arprot;
    logic [NREQ*sword/8-1:0]   s_wstrb;
    logic [sword-1:0]          s_rdata;

    // Fabric side
    logic                      axi_awvalid, axi_wvalid, axi_bready, axi_arvalid, axi_rready;
    logic                      axi_awready, axi_wready, axi_bvalid, axi_arready, axi_rvalid;
    logic [sword-1:0]          axi_awaddr, axi_araddr, axi_wdata;
    logic [2:0]                axi_awprot, axi_arprot;
    logic [sword/8-1:0]        axi_wstrb;
    logic [sword-1:0]          axi_rdata;

    modport master (
        input  s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready,
        input  s_awaddr, s_araddr, s_wdata, s_awprot, s_arprot, s_wstrb,
        output s_awready, s_wready, s_bvalid, s_arready, s_rvalid, s_rdata,
        output axi_awvalid, axi_wvalid, axi_bready, axi_arvalid, axi_rready,
        output axi_awaddr, axi_araddr, axi_wdata, axi_awprot, axi_arprot, axi_wstrb,
        input  axi_awready, axi_wready, axi_bvalid, axi_arready, axi_rvalid, axi_rdata
    );

    modport slave (
        output s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready,
        output s_awaddr, s_araddr, s_wdata, s_awprot, s_arprot, s_wstrb,
        input  s_awready, s_wready, s_bvalid, s_arready, s_rvalid, s_rdata,
        input  axi_awvalid, axi_wvalid, axi_bready, axi_arvalid, axi_rready,
        input  axi_awaddr, axi_araddr, axi_wdata, axi_awprot, axi_arprot, axi_wstrb,
        output axi_awready, axi_wready, axi_bvalid, axi_arready, axi_rvalid, axi_rdata
    );

endinterface

`default_nettype wire

// File: rtl/axi_arb_picker.sv
//==============================================================================
// Module      : axi_arb_picker
// Description : Chooses the winning requester. AXI_ARB_ROUND_ROBIN_EN selects
//               round-robin with a pointer register; otherwise requester 0
//               has fixed priority.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module axi_arb_picker
    import axi_arb_pkg::*;
(
    input  wire logic [NREQ-1:0] i_req,
`ifdef AXI_ARB_ROUND_ROBIN_EN
    input  wire logic            clk,
    input  wire logic            rst,
    input  wire logic            i_complete,
    input  wire logic            i_served,
`endif
    output logic                 o_winner
);

`ifdef AXI_ARB_ROUND_ROBIN_EN
    // Pointer names the requester favoured on the next tie
    logic r_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= 1'b0;
        end else if (i_complete) begin
            r_ptr <= ~i_served;
        end
    end

    always_comb begin
        o_winner = 1'b0;
        if (i_req[REQ_SPI] && i_req[REQ_CPU]) begin
            o_winner = r_ptr;
        end else if (i_req[REQ_CPU]) begin
            o_winner = 1'b1;
        end
    end
`else
    assign o_winner = ~i_req[REQ_SPI] & i_req[REQ_CPU];
`endif

endmodule

`default_nettype wire

// File: rtl/axi_lite_master_arbiter.sv
//==============================================================================
// Module      : axi_lite_master_arbiter
// Description : Grants whole AXI4-lite transactions from two requesters onto
//               one master port with zero-latency pass-through.
//               Optional macro AXI_ARB_ROUND_ROBIN_EN enables round-robin.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module axi_lite_master_arbiter
    import axi_arb_pkg::*;
#(
    parameter int sword = 32
)
(
    input  wire logic                 CLK,
    input  wire logic                 RST,
    axi_lite_master_arbiter_if.master bus
);

    arb_state_e       r_state;
    arb_state_e       w_state_nxt;
    logic             r_grant;
    logic             r_aw_done;
    logic             r_w_done;
    logic             r_ar_done;
    logic             w_winner;
    logic             w_complete;
    logic [NREQ-1:0]  w_req;
    logic             w_aw_hs;
    logic             w_w_hs;
    logic             w_ar_hs;

    assign w_req   = bus.s_awvalid | bus.s_arvalid;
    assign w_aw_hs = bus.axi_awvalid & bus.axi_awready;
    assign w_w_hs  = bus.axi_wvalid  & bus.axi_wready;
    assign w_ar_hs = bus.axi_arvalid & bus.axi_arready;

    axi_arb_picker u_picker (
        .i_req      (w_req),
`ifdef AXI_ARB_ROUND_ROBIN_EN
        .clk        (CLK),
        .rst        (RST),
        .i_complete (w_complete),
        .i_served   (r_grant),
`endif
        .o_winner   (w_winner)
    );

    // Payloads always follow the registered grant, so reset shows requester 0
    assign bus.axi_awaddr = r_grant ? bus.s_awaddr[2*sword-1 -: sword]     : bus.s_awaddr[sword-1:0];
    assign bus.axi_araddr = r_grant ? bus.s_araddr[2*sword-1 -: sword]     : bus.s_araddr[sword-1:0];
    assign bus.axi_wdata  = r_grant ? bus.s_wdata[2*sword-1 -: sword]      : bus.s_wdata[sword-1:0];
    assign bus.axi_wstrb  = r_grant ? bus.s_wstrb[2*sword/8-1 -: sword/8]  : bus.s_wstrb[sword/8-1:0];
    assign bus.axi_awprot = r_grant ? bus.s_awprot[5:3] : bus.s_awprot[2:0];
    assign bus.axi_arprot = r_grant ? bus.s_arprot[5:3] : bus.s_arprot[2:0];
    assign bus.s_rdata    = bus.axi_rdata;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= S_IDLE;
            r_grant   <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_ar_done <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE && (|w_req)) begin
                r_grant <= w_winner;
            end
            if (w_complete) begin
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
                r_ar_done <= 1'b0;
            end else begin
                r_aw_done <= r_aw_done | w_aw_hs;
                r_w_done  <= r_w_done  | w_w_hs;
                r_ar_done <= r_ar_done | w_ar_hs;
            end
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_complete      = 1'b0;
        bus.axi_awvalid = 1'b0;
        bus.axi_wvalid  = 1'b0;
        bus.axi_bready  = 1'b0;
        bus.axi_arvalid = 1'b0;
        bus.axi_rready  = 1'b0;
        bus.s_awready   = '0;
        bus.s_wready    = '0;
        bus.s_bvalid    = '0;
        bus.s_arready   = '0;
        bus.s_rvalid    = '0;

        case (r_state)
            S_IDLE: begin
                // Write wins over read when the winner presents both
                if (|w_req) begin
                    w_state_nxt = bus.s_awvalid[w_winner] ? S_WR : S_RD;
                end
            end
            S_WR: begin
                bus.axi_awvalid         = bus.s_awvalid[r_grant] & ~r_aw_done;
                bus.s_awready[r_grant]  = bus.axi_awready & ~r_aw_done;
                bus.axi_wvalid          = bus.s_wvalid[r_grant] & ~r_w_done;
                bus.s_wready[r_grant]   = bus.axi_wready & ~r_w_done;
                bus.axi_bready          = bus.s_bready[r_grant];
                bus.s_bvalid[r_grant]   = bus.axi_bvalid;
                if (bus.axi_bvalid && bus.s_bready[r_grant]) begin
                    w_state_nxt = S_IDLE;
                    w_complete  = 1'b1;
                end
            end
            S_RD: begin
                bus.axi_arvalid         = bus.s_arvalid[r_grant] & ~r_ar_done;
                bus.s_arready[r_grant]  = bus.axi_arready & ~r_ar_done;
                bus.axi_rready          = bus.s_rready[r_grant];
                bus.s_rvalid[r_grant]   = bus.axi_rvalid;
                if (bus.axi_rvalid && bus.s_rready[r_grant]) begin
                    w_state_nxt = S_IDLE;
                    w_complete  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire
